// File: rtl/cis_pkg.sv
// -----------------------------------------------------------------------------
// cis_pkg
// Shared definitions for the CIS line scheduler:
//   - default geometry (pixels per sub-line, skipped dummy pixels, widths)
//   - colour codes carried on SI_CNT and in the write address
//   - write-address field offsets, expressed as functions of the pixel width
//   - FSM state encoding
// -----------------------------------------------------------------------------
package cis_pkg;

    localparam int PIX_CNT_DEF  = 2592;
    localparam int SKIP_PIX_DEF = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int PIX_W_DEF    = 12;

    localparam int COL_W = 2;

    localparam logic [COL_W-1:0] COL_R = 2'd0;
    localparam logic [COL_W-1:0] COL_G = 2'd1;
    localparam logic [COL_W-1:0] COL_B = 2'd2;

    // WR_ADDR = {bank, colour, pixel}
    localparam int ADDR_PIX_LSB = 0;

    function automatic int addr_col_lsb(input int pix_w);
        return pix_w;
    endfunction

    function automatic int addr_bank_bit(input int pix_w);
        return pix_w + COL_W;
    endfunction

    // Colour that must follow a completed sub-line within a triplet.
    function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] col);
        case (col)
            COL_R:   return COL_G;
            COL_G:   return COL_B;
            default: return COL_R;
        endcase
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WAIT_SI = 2'd3
    } state_e;

endpackage

// File: rtl/cis_bank_tracker.sv
// -----------------------------------------------------------------------------
// cis_bank_tracker
// Owns the ping-pong bank ownership state of the RGB line buffer.
//   CLK, RST       : clock, synchronous active-high reset
//   commit_i       : pulse, a non-dropped triplet has just been fully written
//                    into the current write bank
//   release_i[1:0] : per-bank pulse from the reader, bank has been consumed
//   full_o[1:0]    : bank holds a complete triplet awaiting readout
//   wbank_o        : bank the next triplet is written into
//   tgt_full_o     : the bank the next triplet would target is full; looks
//                    through a commit happening this cycle so a red SI that
//                    lands right on a completion sees the post-toggle bank
// -----------------------------------------------------------------------------
module cis_bank_tracker (
    input  logic       CLK,
    input  logic       RST,
    input  logic       commit_i,
    input  logic [1:0] release_i,
    output logic [1:0] full_o,
    output logic       wbank_o,
    output logic       tgt_full_o
);

    logic [1:0] full_q, full_d;
    logic       wbank_q, wbank_d;

    always_comb begin
        // Releases of banks that are not full simply clear an already-clear bit.
        full_d  = full_q & ~release_i;
        wbank_d = wbank_q;
        if (commit_i) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
        end
    end

    assign tgt_full_o = commit_i ? full_q[~wbank_q] : full_q[wbank_q];
    assign full_o     = full_q;
    assign wbank_o    = wbank_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            full_q  <= 2'b00;
            wbank_q <= 1'b0;
        end else begin
            full_q  <= full_d;
            wbank_q <= wbank_d;
        end
    end

endmodule

// File: rtl/cis_line_scheduler.sv
// -----------------------------------------------------------------------------
// cis_line_scheduler
// Sequences CIS pixel capture for the R, G and B sub-lines started by SI and
// writes them into a two-bank RGB line buffer, handing completed triplets to
// the reader via BANK_FULL / BANK_RELEASE.  Triplets that find their target
// bank still held by the reader are dropped and counted.
//
// Ports:
//   CLK, RST       : clock, synchronous active-high reset
//   ENABLE         : capture enable, only looked at in IDLE
//   SI, SI_CNT     : sensor start pulse and the colour of that sub-line
//   PIX_VALID/DATA : ADC sample strobe and sample
//   WR_EN/ADDR/DATA: line-buffer write port, WR_ADDR = {bank, colour, pixel}
//   BANK_FULL      : per-bank "complete triplet waiting" flags
//   BANK_RELEASE   : per-bank pulse from the reader
//   LINE_NUM       : completed triplets (wraps)
//   DROP_CNT       : dropped triplets (saturates)
//   LINE_ERR       : sticky, a sub-line was cut short by an early SI
//
// Build option: define CIS_SCHED_TEST_PATTERN_EN to replace PIX_DATA with
// {colour, LINE_NUM[5:0], pixel index} on WR_DATA; timing is unchanged.
// -----------------------------------------------------------------------------
module cis_line_scheduler
    import cis_pkg::*;
#(
    parameter int PIX_CNT  = PIX_CNT_DEF,
    parameter int SKIP_PIX = SKIP_PIX_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PIX_W    = PIX_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic              SI,
    input  logic [1:0]        SI_CNT,
    input  logic              PIX_VALID,
    input  logic [DATA_W-1:0] PIX_DATA,
    output logic              WR_EN,
    output logic [PIX_W+2:0]  WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic [1:0]        BANK_FULL,
    input  logic [1:0]        BANK_RELEASE,
    output logic [15:0]       LINE_NUM,
    output logic [15:0]       DROP_CNT,
    output logic              LINE_ERR
);

    localparam int AW       = PIX_W + 3;
    localparam int COL_LSB  = addr_col_lsb(PIX_W);
    localparam int BANK_BIT = addr_bank_bit(PIX_W);

    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(PIX_CNT - 1);
    localparam logic [PIX_W-1:0] LAST_SKIP = PIX_W'(SKIP_PIX - 1);

    state_e             state_q, state_d;
    logic               si_q, si_d;
    logic [COL_W-1:0]   cur_col_q, cur_col_d;
    logic               col_vld_q, col_vld_d;   // cur_col holds a real colour
    logic [COL_W-1:0]   exp_col_q, exp_col_d;
    logic [PIX_W-1:0]   cnt_q, cnt_d;           // skip count, then pixel index
    logic               drop_q, drop_d;         // current triplet is dropped
    logic               line_err_q, line_err_d;
    logic               wr_en_q, wr_en_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               complete_q, complete_d; // high on the last blue write
    logic               done_drop_q, done_drop_d;
    logic [15:0]        line_num_q, line_num_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;

    logic si_rise, flush, rise, rise_r;
    logic start_trip, abort;
    logic commit, drop_evt;
    logic wbank, tgt_full;

    // Completion takes effect on the edge that ends the last blue write cycle.
    assign commit   = complete_q & ~done_drop_q;
    assign drop_evt = complete_q &  done_drop_q;

    cis_bank_tracker u_banks (
        .CLK        (CLK),
        .RST        (RST),
        .commit_i   (commit),
        .release_i  (BANK_RELEASE),
        .full_o     (BANK_FULL),
        .wbank_o    (wbank),
        .tgt_full_o (tgt_full)
    );

    // A rise repeating the colour already latched is a flush pulse; the very
    // first rise after reset can never be one.
    assign si_rise = SI & ~si_q;
    assign flush   = si_rise & col_vld_q & (SI_CNT == cur_col_q);
    assign rise    = si_rise & ~flush;
    assign rise_r  = rise & (SI_CNT == COL_R);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d     = state_q;
        si_d        = SI;
        cur_col_d   = si_rise ? SI_CNT : cur_col_q;
        col_vld_d   = col_vld_q | si_rise;
        exp_col_d   = exp_col_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        line_err_d  = line_err_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        complete_d  = 1'b0;
        done_drop_d = done_drop_q;
        start_trip  = 1'b0;
        abort       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Capture only ever starts on red; G/B rises here are ignored.
                if (rise_r && ENABLE) start_trip = 1'b1;
            end

            ST_SKIP: begin
                if (rise) begin
                    abort = 1'b1;
                end else if (PIX_VALID) begin
                    if (cnt_q == LAST_SKIP) begin
                        state_d = ST_CAPTURE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + PIX_W'(1);
                    end
                end
            end

            ST_CAPTURE: begin
                if (rise) begin
                    abort = 1'b1;
                end else if (PIX_VALID) begin
                    // Dropped triplets keep counting but never write.
                    wr_en_d                           = ~drop_q;
                    wr_addr_d[BANK_BIT]               = wbank;
                    wr_addr_d[COL_LSB +: COL_W]       = cur_col_q;
                    wr_addr_d[ADDR_PIX_LSB +: PIX_W]  = cnt_q;
`ifdef CIS_SCHED_TEST_PATTERN_EN
                    wr_data_d = DATA_W'({cur_col_q, line_num_q[5:0], cnt_q});
`else
                    wr_data_d = PIX_DATA;
`endif
                    if (cnt_q == LAST_PIX) begin
                        cnt_d = '0;
                        if (cur_col_q == COL_B) begin
                            complete_d  = 1'b1;
                            done_drop_d = drop_q;
                            exp_col_d   = COL_R;
                            state_d     = ST_IDLE;
                        end else begin
                            exp_col_d = next_col(cur_col_q);
                            state_d   = ST_WAIT_SI;
                        end
                    end else begin
                        cnt_d = cnt_q + PIX_W'(1);
                    end
                end
            end

            ST_WAIT_SI: begin
                if (rise) begin
                    if (SI_CNT == exp_col_q) begin
                        state_d = ST_SKIP;
                        cnt_d   = '0;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Out-of-order or early SI: the partial triplet is abandoned, and a
        // red rise immediately begins a fresh one.
        if (abort) begin
            line_err_d = 1'b1;
            exp_col_d  = COL_R;
            state_d    = ST_IDLE;
            start_trip = rise_r;
        end

        // The drop decision for the whole triplet is taken at its red rise.
        if (start_trip) begin
            state_d   = ST_SKIP;
            cnt_d     = '0;
            drop_d    = tgt_full;
            exp_col_d = COL_R;
        end

        line_num_d = commit ? line_num_q + 16'd1 : line_num_q;
        drop_cnt_d = (drop_evt && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values computed before this edge regardless of block order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            si_q        <= 1'b0;
            cur_col_q   <= COL_R;
            col_vld_q   <= 1'b0;
            exp_col_q   <= COL_R;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            line_err_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            complete_q  <= 1'b0;
            done_drop_q <= 1'b0;
            line_num_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            si_q        <= si_d;
            cur_col_q   <= cur_col_d;
            col_vld_q   <= col_vld_d;
            exp_col_q   <= exp_col_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            line_err_q  <= line_err_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            complete_q  <= complete_d;
            done_drop_q <= done_drop_d;
            line_num_q  <= line_num_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign WR_EN    = wr_en_q;
    assign WR_ADDR  = wr_addr_q;
    assign WR_DATA  = wr_data_q;
    assign LINE_NUM = line_num_q;
    assign DROP_CNT = drop_cnt_q;
    assign LINE_ERR = line_err_q;

endmodule

// File: tb/tb_cis_line_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cis_line_scheduler
// Randomised and directed stimulus for cis_line_scheduler with a short line
// (PIX_CNT=40, SKIP_PIX=4).  A sub-line-level reference model predicts every
// line-buffer write into a queue; a monitor pops and compares on each WR_EN.
// Bank/counter/error status is compared against the model between operations.
// -----------------------------------------------------------------------------
module tb_cis_line_scheduler;

    localparam int PIX_CNT  = 40;
    localparam int SKIP_PIX = 4;
    localparam int DATA_W   = 16;
    localparam int PIX_W    = 12;
    localparam int AW       = PIX_W + 3;
    localparam int FULL_SUB = SKIP_PIX + PIX_CNT;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              ENABLE = 1'b0;
    logic              SI = 1'b0;
    logic [1:0]        SI_CNT = 2'd0;
    logic              PIX_VALID = 1'b0;
    logic [DATA_W-1:0] PIX_DATA = '0;
    logic              WR_EN;
    logic [AW-1:0]     WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic [1:0]        BANK_FULL;
    logic [1:0]        BANK_RELEASE = 2'b00;
    logic [15:0]       LINE_NUM;
    logic [15:0]       DROP_CNT;
    logic              LINE_ERR;

    cis_line_scheduler #(
        .PIX_CNT  (PIX_CNT),
        .SKIP_PIX (SKIP_PIX),
        .DATA_W   (DATA_W),
        .PIX_W    (PIX_W)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ENABLE       (ENABLE),
        .SI           (SI),
        .SI_CNT       (SI_CNT),
        .PIX_VALID    (PIX_VALID),
        .PIX_DATA     (PIX_DATA),
        .WR_EN        (WR_EN),
        .WR_ADDR      (WR_ADDR),
        .WR_DATA      (WR_DATA),
        .BANK_FULL    (BANK_FULL),
        .BANK_RELEASE (BANK_RELEASE),
        .LINE_NUM     (LINE_NUM),
        .DROP_CNT     (DROP_CNT),
        .LINE_ERR     (LINE_ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef enum int {P_IDLE, P_RUN, P_WAIT} phase_e;

    wr_t    exp_q[$];
    bit     m_full[2];
    bit     m_wbank;
    int     m_line;
    int     m_drop;
    bit     m_err;
    bit     m_last_vld;
    int     m_last_col;
    phase_e m_phase;
    int     m_cur;
    int     m_exp;
    bit     m_dropped;
    int     m_k;

    task automatic model_reset();
        exp_q.delete();
        m_full[0] = 0; m_full[1] = 0;
        m_wbank = 0; m_line = 0; m_drop = 0; m_err = 0;
        m_last_vld = 0; m_last_col = 0;
        m_phase = P_IDLE; m_cur = 0; m_exp = 0; m_dropped = 0; m_k = 0;
    endtask

    task automatic model_start();
        m_dropped = m_full[m_wbank];
        m_phase   = P_RUN;
        m_cur     = 0;
        m_k       = 0;
    endtask

    task automatic model_si(input int col);
        if (m_last_vld && col == m_last_col) return;   // flush pulse
        m_last_vld = 1;
        m_last_col = col;
        case (m_phase)
            P_IDLE: if (col == 0 && ENABLE) model_start();
            P_RUN: begin
                m_err = 1;
                if (col == 0) model_start(); else m_phase = P_IDLE;
            end
            default: begin
                if (col == m_exp) begin
                    m_phase = P_RUN; m_cur = col; m_k = 0;
                end else begin
                    m_err = 1;
                    if (col == 0) model_start(); else m_phase = P_IDLE;
                end
            end
        endcase
    endtask

    task automatic model_pix(input logic [DATA_W-1:0] d);
        int  idx;
        wr_t e;
        if (m_phase != P_RUN) return;
        m_k++;
        if (m_k <= SKIP_PIX) return;
        idx = m_k - SKIP_PIX - 1;
        if (!m_dropped) begin
            e.addr = {m_wbank, 2'(m_cur), PIX_W'(idx)};
            e.data = d;
            exp_q.push_back(e);
        end
        if (idx == PIX_CNT - 1) begin
            if (m_cur == 2) begin
                if (!m_dropped) begin
                    m_full[m_wbank] = 1;
                    m_wbank = ~m_wbank;
                    m_line  = (m_line + 1) % 65536;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
                m_phase = P_IDLE;
            end else begin
                m_phase = P_WAIT;
                m_exp   = m_cur + 1;
            end
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge CLK) begin
        if (WR_EN) begin
            wr_t e;
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", 32'(WR_ADDR), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(WR_ADDR), 32'(e.addr));
                check("wr_data", 32'(WR_DATA), 32'(e.data));
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic si(input int col);
        int len;
        len    = 4 + $urandom_range(0, 1);
        SI_CNT = 2'(col);
        SI     = 1'b1;
        model_si(col);
        repeat (len) tick();
        SI = 1'b0;
        tick();
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            PIX_VALID = 1'b1;
            PIX_DATA  = DATA_W'($urandom);
            model_pix(PIX_DATA);
            tick();
            PIX_VALID = 1'b0;
        end
        repeat (3) tick();
    endtask

    task automatic subline(input int col, input int n);
        si(col);
        pixels(n);
    endtask

    task automatic triplet();
        subline(0, FULL_SUB);
        subline(1, FULL_SUB);
        subline(2, FULL_SUB);
    endtask

    task automatic release_bank(input int b);
        BANK_RELEASE = 2'b01 << b;
        tick();
        BANK_RELEASE = 2'b00;
        m_full[b] = 0;
        repeat (2) tick();
    endtask

    task automatic status(input string tag);
        check({tag, "_line_num"},  32'(LINE_NUM),  32'(m_line));
        check({tag, "_drop_cnt"},  32'(DROP_CNT),  32'(m_drop));
        check({tag, "_bank_full"}, 32'(BANK_FULL), {30'd0, m_full[1], m_full[0]});
        check({tag, "_line_err"},  32'(LINE_ERR),  32'(m_err));
        check({tag, "_pending"},   32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},     32'(WR_EN),     32'd0);
        check({tag, "_wr_addr"},   32'(WR_ADDR),   32'd0);
        check({tag, "_wr_data"},   32'(WR_DATA),   32'd0);
        check({tag, "_bank_full"}, 32'(BANK_FULL), 32'd0);
        check({tag, "_line_num"},  32'(LINE_NUM),  32'd0);
        check({tag, "_drop_cnt"},  32'(DROP_CNT),  32'd0);
        check({tag, "_line_err"},  32'(LINE_ERR),  32'd0);
    endtask

    // --------------------------------------------------------------- watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------- main test
    initial begin
        model_reset();
        repeat (3) tick();
        check_all_zero("reset");
        RST = 1'b0;
        tick();

        // First triplet lands in bank 0.
        ENABLE = 1'b1;
        triplet();
        status("t1");
        check("t1_bank_full_01", 32'(BANK_FULL), 32'd1);
        check("t1_line_num_1", 32'(LINE_NUM), 32'd1);
        check("t1_writes", 32'(n_writes), 32'(3 * PIX_CNT));

        // Second fills bank 1, third finds bank 0 held and is dropped.
        triplet();
        status("t2");
        triplet();
        status("t3");
        check("t3_drop_cnt_1", 32'(DROP_CNT), 32'd1);
        check("t3_bank_full_11", 32'(BANK_FULL), 32'd3);
        check("t3_no_writes", 32'(n_writes), 32'(6 * PIX_CNT));

        // Release bank 0; the fourth triplet goes there.
        release_bank(0);
        status("rel0");
        triplet();
        status("t4");
        check("t4_line_num_3", 32'(LINE_NUM), 32'd3);
        release_bank(0);
        release_bank(1);
        status("rel_both");

        // Flush pulse after the red sub-line changes nothing.
        subline(0, FULL_SUB);
        si(0);
        subline(1, FULL_SUB);
        subline(2, FULL_SUB);
        status("flush");
        check("flush_no_err", 32'(LINE_ERR), 32'd0);

        // Green SI after half a red line: error, back to IDLE, pixels ignored.
        subline(0, SKIP_PIX + PIX_CNT / 2);
        subline(1, FULL_SUB);
        status("trunc");
        check("trunc_err", 32'(LINE_ERR), 32'd1);
        subline(2, FULL_SUB);
        triplet();
        status("after_trunc");

        // Reset in the middle of green capture.
        subline(0, FULL_SUB);
        subline(1, SKIP_PIX + 10);
        RST = 1'b1;
        tick();
        check_all_zero("midreset");
        RST = 1'b0;
        model_reset();
        tick();
        triplet();
        status("post_reset");
        check("post_reset_bank0", 32'(BANK_FULL), 32'd1);

        // Randomised triplets with truncations, flushes, enables and releases.
        for (int it = 0; it < 30; it++) begin
            ENABLE = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < 3; c++) begin
                int col;
                int n;
                col = c;
                if ($urandom_range(0, 7) == 0) col = $urandom_range(0, 2);
                n = ($urandom_range(0, 7) == 0) ? $urandom_range(1, FULL_SUB) : FULL_SUB;
                subline(col, n);
                if ($urandom_range(0, 5) == 0) si(col);
            end
            if ($urandom_range(0, 2) != 0) release_bank($urandom_range(0, 1));
            status("rand");
        end

        repeat (5) tick();
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cis_line_scheduler.md
Name: cis_line_scheduler

Overview:
- Sequences CIS pixel capture for each colour sub-line (R, G, B) after every SI start pulse.
- Writes the pixels into a two-bank (ping-pong) RGB line buffer and hands each completed RGB triplet to the readout side with a full/release handshake.
- Sits between the CIS timing generator (SI, SI_CNT) plus ADC sample strobe, and the line-buffer RAM plus readout DMA.
- Drops triplets when both banks are held by the reader, and reports the drops.

Parameters:
- PIX_CNT, 2592, active pixels per colour sub-line.
- SKIP_PIX, 16, dummy pixels discarded after each SI before capture starts.
- DATA_W, 16, ADC sample width.
- PIX_W, 12, pixel index width; must satisfy 2^PIX_W >= PIX_CNT.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- ENABLE  in  1  capture enable; sampled only in IDLE.
- SI  in  1  sensor start pulse, 4–5 cycles high.
- SI_CNT  in  2  colour of the sub-line started by SI: 0=R, 1=G, 2=B.
- PIX_VALID  in  1  ADC sample strobe, at most one per cycle.
- PIX_DATA  in  DATA_W  ADC sample.
- WR_EN  out  1  line-buffer write strobe.
- WR_ADDR  out  PIX_W+3  {bank[1], colour[2], pixel[PIX_W]}.
- WR_DATA  out  DATA_W  write data.
- BANK_FULL  out  2  bank holds a complete RGB triplet awaiting readout.
- BANK_RELEASE  in  2  one-cycle pulse per bank; reader has finished with that bank.
- LINE_NUM  out  16  count of completed triplets, wraps.
- DROP_CNT  out  16  count of dropped triplets, saturates at 0xFFFF.
- LINE_ERR  out  1  sticky; a sub-line was truncated by an early SI.

Behaviour:
- All outputs reset to 0. Internal state on reset: write bank = 0, expected colour = R, FSM = IDLE.
- Reset mid-operation discards any partial triplet; BANK_FULL is cleared.
- SI is rising-edge detected; SI_CNT is latched on the rise cycle as cur_col.
- A rise whose SI_CNT equals the previously latched colour is a flush pulse and is ignored in every state.
- FSM states: IDLE, SKIP, CAPTURE, WAIT_SI.
- IDLE → SKIP on SI rise, when ENABLE=1 and cur_col=R. SI rises with G/B while in IDLE are ignored; capture always starts at red.
- SKIP: count PIX_VALID strobes; the first SKIP_PIX are discarded. → CAPTURE after the SKIP_PIX-th valid strobe.
- CAPTURE: each PIX_VALID writes one pixel, 1-cycle registered latency.
  - WR_ADDR = {wbank, cur_col, pix_idx}; pix_idx runs 0..PIX_CNT-1.
  - WR_EN is forced to 0 when the triplet is marked dropped; counting continues.
  - After pixel PIX_CNT-1: if cur_col=B → triplet complete; else → WAIT_SI with expected colour = cur_col+1.
- WAIT_SI → SKIP on SI rise with SI_CNT = expected colour.
  - Rise with any other non-flush colour: abort the triplet, set LINE_ERR, restart at SKIP if that colour is R, else go to IDLE.
- SI rise during SKIP or CAPTURE (not a flush): truncated sub-line. Set LINE_ERR, abort the triplet, handle as in WAIT_SI.
- Drop decision is made at the red SI rise: if BANK_FULL[wbank]=1, the whole triplet is marked dropped.
- Triplet completion, one cycle after the last blue write:
  - If not dropped: BANK_FULL[wbank] <= 1, wbank toggles, LINE_NUM++.
  - If dropped: DROP_CNT++ (saturating); wbank is unchanged.
  - Next state is IDLE, or SKIP directly if an R rise arrives on the same cycle.
- BANK_RELEASE[b] clears BANK_FULL[b] on the next cycle. A release for a bank that is not full is ignored.
- Completion of one bank and release of the other in the same cycle both take effect.
- ENABLE=0 takes effect at the next return to IDLE; a triplet in progress finishes.

Optional Feature:
- Macro CIS_SCHED_TEST_PATTERN_EN.
- Defined: WR_DATA = {cur_col, LINE_NUM[5:0], pix_idx} truncated or zero-extended to DATA_W. PIX_DATA is ignored; timing is identical.
- Not defined: WR_DATA = PIX_DATA, registered.

Decomposition:
- Shared package cis_pkg holds:
  - PIX_CNT and SKIP_PIX defaults, PIX_W.
  - Colour codes COL_R=0, COL_G=1, COL_B=2.
  - WR_ADDR field offsets.
  - FSM state encoding.
- One sub-module, cis_bank_tracker: owns BANK_FULL[1:0], wbank toggle and release handling, and exposes a target-full flag for the drop decision.

Test Plan:
- ENABLE=1, SI sequence R,G,B each followed by 2608 PIX_VALID → 7776 writes, addresses 0x0000..0x0A1F / 0x1000.. / 0x2000.. in bank 0; BANK_FULL=01, LINE_NUM=1.
- Two triplets, no release, then a third → third has no WR_EN, DROP_CNT=1, BANK_FULL=11. Pulse BANK_RELEASE=01, run a fourth → it lands in bank 0, LINE_NUM=3.
- Flush pulse (SI with SI_CNT=0 repeated right after the red sub-line) → no state change, no LINE_ERR.
- SI with G after only 1000 red pixels → LINE_ERR=1, FSM returns to IDLE, no BANK_FULL change; the next R,G,B triplet completes normally.
- RST asserted mid green capture → next cycle all outputs are 0; the following triplet is written to bank 0.
- With CIS_SCHED_TEST_PATTERN_EN, first triplet, blue pixel 5 → WR_DATA = {2'b10, 6'd0, 12'd5}.
